// File: rtl/alu_exec_unit_if.sv
// Instruction handshake and retire strobes between the issuing CPU front end and alu_exec_unit.
interface alu_exec_unit_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        done;
  logic        illegal;

  modport master (output instr_valid, output instr, input instr_ready, input done, input illegal);
  modport slave  (input instr_valid, input instr, output instr_ready, output done, output illegal);
endinterface

// File: rtl/alu_exec_unit.sv
// Execute unit: GPR file, single-cycle mov/arith/logic ops and an iterative shift-add multiply.
//   state | meaning
//   IDLE  | ready for an instruction; operands latched on accept
//   EXEC  | single-cycle op; writeback and flag update on the leaving edge
//   MUL   | one shift-add iteration per cycle; writeback on the last iteration
module alu_exec_unit #(
  parameter int DATA_W = 16,
  parameter int NREG   = 32,
  localparam int AW    = (NREG > 1) ? $clog2(NREG) : 1,
  localparam int CW    = $clog2(DATA_W)
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_exec_unit_if.slave      bus,
  output logic [3:0]          flags,
  output logic [DATA_W-1:0]   sgpr,
  input  logic [AW-1:0]       dbg_addr,
  output logic [DATA_W-1:0]   dbg_data
);

  localparam logic [4:0] OP_MOVSGPR = 5'd0;
  localparam logic [4:0] OP_MOV     = 5'd1;
  localparam logic [4:0] OP_ADD     = 5'd2;
  localparam logic [4:0] OP_SUB     = 5'd3;
  localparam logic [4:0] OP_MUL     = 5'd4;
  localparam logic [4:0] OP_OR      = 5'd5;
  localparam logic [4:0] OP_AND     = 5'd6;
  localparam logic [4:0] OP_XOR     = 5'd7;
  localparam logic [4:0] OP_XNOR    = 5'd8;
  localparam logic [4:0] OP_NAND    = 5'd9;
  localparam logic [4:0] OP_NOR     = 5'd10;
  localparam logic [4:0] OP_NOT     = 5'd11;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   gpr [NREG];
  logic [4:0]          op_q;
  logic [AW-1:0]       rd_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic                imm_q;
  logic [CW-1:0]       mul_cnt;
  logic [2*DATA_W-1:0] acc;

  logic [AW-1:0]       rd_in, rs1_in, rs2_in;
  logic [DATA_W-1:0]   b_in;

  assign rd_in  = bus.instr[22 +: AW];
  assign rs1_in = bus.instr[17 +: AW];
  assign rs2_in = bus.instr[11 +: AW];
  assign b_in   = bus.instr[16] ? DATA_W'(bus.instr[15:0]) : gpr[rs2_in];

  assign dbg_data = gpr[dbg_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    bus.instr_ready = 1'b0;
    case (state)
      S_IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid)
          state_nxt = (bus.instr[31:27] == OP_MUL) ? S_MUL : S_EXEC;
      end
      S_EXEC:  state_nxt = S_IDLE;
      S_MUL:   if (mul_cnt == '0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  logic [DATA_W:0]   sum, diff;
  logic [DATA_W-1:0] res;
  logic              c_res, v_res, legal;

  always_comb begin
    sum   = {1'b0, a_q} + {1'b0, b_q};
    diff  = {1'b0, a_q} - {1'b0, b_q};
    res   = '0;
    c_res = 1'b0;
    v_res = 1'b0;
    legal = 1'b1;
    case (op_q)
      OP_MOVSGPR: res = sgpr;
      OP_MOV:     res = b_q;
      OP_ADD: begin
        res   = sum[DATA_W-1:0];
        c_res = sum[DATA_W];
        v_res = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (sum[DATA_W-1] != a_q[DATA_W-1]);
      end
      OP_SUB: begin
        res   = diff[DATA_W-1:0];
        c_res = diff[DATA_W];
        v_res = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (diff[DATA_W-1] != a_q[DATA_W-1]);
      end
      OP_OR:   res = a_q | b_q;
      OP_AND:  res = a_q & b_q;
      OP_XOR:  res = a_q ^ b_q;
      OP_XNOR: res = ~(a_q ^ b_q);
      OP_NAND: res = ~(a_q & b_q);
      OP_NOR:  res = ~(a_q | b_q);
      OP_NOT:  res = imm_q ? ~b_q : ~a_q;
      default: legal = 1'b0;
    endcase
  end

  // acc holds {partial high word, remaining multiplier bits}; each step adds and shifts right.
  logic [DATA_W:0]     mul_add;
  logic [2*DATA_W:0]   mul_sh;
  logic [2*DATA_W-1:0] acc_nxt;

  always_comb begin
    mul_add = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, a_q} : '0);
    mul_sh  = {mul_add, acc[DATA_W-1:0]};
    acc_nxt = mul_sh[2*DATA_W:1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
      sgpr        <= '0;
      flags       <= '0;
      bus.done    <= 1'b0;
      bus.illegal <= 1'b0;
      op_q        <= '0;
      rd_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      imm_q       <= 1'b0;
      mul_cnt     <= '0;
      acc         <= '0;
    end else begin
      bus.done    <= 1'b0;
      bus.illegal <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.instr_valid) begin
            op_q    <= bus.instr[31:27];
            rd_q    <= rd_in;
            a_q     <= gpr[rs1_in];
            b_q     <= b_in;
            imm_q   <= bus.instr[16];
            acc     <= {{DATA_W{1'b0}}, b_in};
            mul_cnt <= CW'(DATA_W - 1);
          end
        end
        S_EXEC: begin
          bus.done    <= 1'b1;
          bus.illegal <= !legal;
          if (legal) begin
            gpr[rd_q] <= res;
            flags     <= {v_res, c_res, res[DATA_W-1], res == '0};
          end
        end
        S_MUL: begin
          acc <= acc_nxt;
          if (mul_cnt == '0) begin
            gpr[rd_q] <= acc_nxt[DATA_W-1:0];
            sgpr      <= acc_nxt[2*DATA_W-1:DATA_W];
            flags     <= {acc_nxt[2*DATA_W-1:DATA_W] != '0, acc_nxt[2*DATA_W-1:DATA_W] != '0,
                          acc_nxt[DATA_W-1], acc_nxt == '0};
            bus.done  <= 1'b1;
          end else begin
            mul_cnt <= mul_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed table, handshake/reset corner cases, random vs. model.
module tb_alu_exec_unit;
  localparam int W    = 16;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);
  localparam longint MASK = (longint'(1) << W) - 1;
  localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (W - 1));

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    flags;
  logic [W-1:0]  sgpr;
  logic [AW-1:0] dbg_addr = '0;
  logic [W-1:0]  dbg_data;

  alu_exec_unit_if bus ();

  alu_exec_unit #(.DATA_W(W), .NREG(NREG)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .flags(flags), .sgpr(sgpr),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  always @(negedge clk) if (bus.done) done_cnt++;

  longint mreg [NREG];
  longint msgpr, mflags;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic longint sx(input longint x);
    return (x >= (longint'(1) << (W - 1))) ? x - (longint'(1) << W) : x;
  endfunction

  function automatic logic [31:0] mk(input int op, input int rd, input int rs1, input bit imm, input logic [15:0] lo);
    logic [4:0] o, d, s;
    o = 5'(op); d = 5'(rd); s = 5'(rs1);
    return {o, d, s, imm, lo};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) mreg[i] = 0;
    msgpr = 0; mflags = 0;
  endtask

  task automatic model_exec(input logic [31:0] ins);
    int op, rd, r1, r2;
    longint a, b, res, p, hi, d;
    bit c, v, wr;
    op = int'(ins[31:27]); rd = int'(ins[26:22]) % NREG;
    r1 = int'(ins[21:17]) % NREG; r2 = int'(ins[15:11]) % NREG;
    a = mreg[r1];
    b = ins[16] ? (longint'(ins[15:0]) & MASK) : mreg[r2];
    c = 0; v = 0; wr = 1; res = 0;
    case (op)
      0:  res = msgpr;
      1:  res = b;
      2:  begin res = (a + b) & MASK; c = (a + b) > MASK; d = sx(a) + sx(b); v = (d > SMAX) || (d < SMIN); end
      3:  begin res = (a - b) & MASK; c = a < b; d = sx(a) - sx(b); v = (d > SMAX) || (d < SMIN); end
      4:  begin
            p = a * b; res = p & MASK; hi = (p >> W) & MASK;
            mreg[rd] = res; msgpr = hi;
            mflags = ((hi != 0) ? 12 : 0) + ((res >> (W - 1)) & 1) * 2 + ((p == 0) ? 1 : 0);
            wr = 0;
          end
      5:  res = a | b;
      6:  res = a & b;
      7:  res = a ^ b;
      8:  res = ~(a ^ b) & MASK;
      9:  res = ~(a & b) & MASK;
      10: res = ~(a | b) & MASK;
      11: res = ~(ins[16] ? b : a) & MASK;
      default: wr = 0;
    endcase
    if (wr) begin
      mreg[rd] = res;
      mflags = (v ? 8 : 0) + (c ? 4 : 0) + ((res >> (W - 1)) & 1) * 2 + ((res == 0) ? 1 : 0);
    end
  endtask

  // Issues one instruction, checks handshake timing and retire strobes, then compares state to the model.
  task automatic send(input logic [31:0] ins);
    int op, lat, w, exp_lat, rd;
    bit ready_bad;
    op = int'(ins[31:27]);
    rd = int'(ins[26:22]) % NREG;
    exp_lat = (op == 4) ? W : 1;
    for (w = 0; w < 40 && !bus.instr_ready; w++) @(negedge clk);
    if (!bus.instr_ready) chk("ready_timeout", 0, 1);
    bus.instr_valid = 1'b1;
    bus.instr = ins;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    bus.instr = $urandom;
    ready_bad = 0;
    for (lat = 0; lat < 60; lat++) begin
      @(negedge clk);
      if (bus.done) break;
      if (bus.instr_ready) ready_bad = 1;
    end
    chk($sformatf("latency op%0d", op), lat, exp_lat);
    chk("illegal_flag", bus.illegal, (op > 11) ? 1 : 0);
    chk("ready_low_busy", ready_bad, 0);
    model_exec(ins);
    dbg_addr = AW'(rd);
    #1;
    chk($sformatf("gpr[%0d]", rd), dbg_data, mreg[rd]);
    chk("flags", flags, mflags);
    chk("sgpr", sgpr, msgpr);
    @(negedge clk);
    chk("done_one_cycle", bus.done, 0);
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [W-1:0] exp_val;
    logic [3:0]  exp_flags;
    logic [W-1:0] exp_sgpr;
  } vec_t;

  vec_t vt [12];

  initial begin
    int acc_cnt, last, gap_bad, d0, errs;
    bit r;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    model_reset();

    vt[0]  = '{mk(1, 1, 0, 1, 16'h7FFF),       16'h7FFF, 4'b0000, 16'h0000};
    vt[1]  = '{mk(2, 2, 1, 1, 16'h0001),       16'h8000, 4'b1010, 16'h0000};
    vt[2]  = '{mk(1, 3, 0, 1, 16'h0005),       16'h0005, 4'b0000, 16'h0000};
    vt[3]  = '{mk(3, 4, 3, 0, {5'd3, 11'd0}),  16'h0000, 4'b0001, 16'h0000};
    vt[4]  = '{mk(3, 4, 3, 1, 16'h0006),       16'hFFFF, 4'b0110, 16'h0000};
    vt[5]  = '{mk(1, 5, 0, 1, 16'h1234),       16'h1234, 4'b0000, 16'h0000};
    vt[6]  = '{mk(4, 6, 5, 1, 16'h0100),       16'h3400, 4'b1100, 16'h0012};
    vt[7]  = '{mk(0, 7, 0, 0, 16'h0000),       16'h0012, 4'b0000, 16'h0012};
    vt[8]  = '{mk(7, 8, 5, 1, 16'h00FF),       16'h12CB, 4'b0000, 16'h0012};
    vt[9]  = '{mk(11, 9, 0, 1, 16'h0000),      16'hFFFF, 4'b0010, 16'h0012};
    vt[10] = '{mk(9, 10, 5, 0, {5'd5, 11'd0}), 16'hEDCB, 4'b0010, 16'h0012};
    vt[11] = '{mk(5, 11, 0, 1, 16'h0000),      16'h0000, 4'b0001, 16'h0012};

    repeat (3) @(negedge clk);
    chk("reset_flags", flags, 0);
    chk("reset_sgpr", sgpr, 0);
    chk("reset_done", bus.done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", bus.instr_ready, 1);

    foreach (vt[i]) begin
      send(vt[i].ins);
      dbg_addr = vt[i].ins[22 +: AW];
      #1;
      chk($sformatf("vec%0d_val", i), dbg_data, vt[i].exp_val);
      chk($sformatf("vec%0d_flags", i), flags, vt[i].exp_flags);
      chk($sformatf("vec%0d_sgpr", i), sgpr, vt[i].exp_sgpr);
    end

    send(mk(31, 1, 2, 1, 16'hABCD));
    dbg_addr = AW'(1);
    #1;
    chk("illegal_keeps_r1", dbg_data, 16'h7FFF);
    chk("illegal_keeps_flags", flags, 4'b0001);

    // Back-to-back movs with instr_valid held high.
    d0 = done_cnt; acc_cnt = 0; last = -1; gap_bad = 0;
    bus.instr_valid = 1'b1;
    bus.instr = mk(1, 12, 0, 1, 16'h0100);
    for (int cyc = 0; cyc < 40 && acc_cnt < 4; cyc++) begin
      r = bus.instr_ready;
      @(posedge clk);
      if (r) begin
        if (acc_cnt > 0 && cyc - last != 2) gap_bad++;
        last = cyc;
        acc_cnt++;
        #1 bus.instr = mk(1, 12 + acc_cnt, 0, 1, 16'(16'h0100 + acc_cnt));
      end
      @(negedge clk);
    end
    bus.instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_accepts", acc_cnt, 4);
    chk("b2b_gap", gap_bad, 0);
    chk("b2b_dones", done_cnt - d0, 4);
    for (int i = 0; i < 4; i++) begin
      mreg[12 + i] = 'h100 + i;
      dbg_addr = AW'(12 + i);
      #1 chk($sformatf("b2b_r%0d", 12 + i), dbg_data, mreg[12 + i]);
    end
    mflags = 0;
    chk("b2b_flags", flags, 0);
    d0 = done_cnt;
    repeat (5) @(negedge clk);
    chk("idle_no_done", done_cnt - d0, 0);

    // Reset five cycles into a multiply.
    bus.instr_valid = 1'b1;
    bus.instr = mk(4, 20, 5, 1, 16'h0100);
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    d0 = done_cnt;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_reset_ready", bus.instr_ready, 1);
    errs = 0;
    for (int i = 0; i < NREG; i++) begin
      dbg_addr = AW'(i);
      #1 if (dbg_data != '0) errs++;
    end
    chk("reset_regs_nonzero", errs, 0);
    chk("reset_sgpr_mid_mul", sgpr, 0);
    chk("reset_flags_mid_mul", flags, 0);
    model_reset();
    @(negedge clk);
    send(mk(1, 3, 0, 1, 16'h00A5));
    repeat (20) @(negedge clk);
    chk("reset_mul_no_done", done_cnt - d0, 1);

    // Random instructions against the model.
    for (int n = 0; n < 80; n++) begin
      int sel;
      logic [4:0] op;
      logic [31:0] rnd;
      sel = $urandom_range(0, 13);
      op = (sel < 12) ? 5'(sel) : 5'($urandom_range(12, 31));
      rnd = $urandom;
      send({op, rnd[26:0]});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
